// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared constants and types for the MEM pipeline stage:
//               memory-op / control-op / exception encodings, bus_if state
//               encoding and active-high / active-low enable levels.
//               Reset everywhere is active-low and taken on its falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

   // Enable levels for active-high and active-low (trailing '_') signals
   localparam logic ENABLE       = 1'b1;
   localparam logic DISABLE      = 1'b0;
   localparam logic ENABLE_      = 1'b0;
   localparam logic DISABLE_     = 1'b1;
   localparam logic RESET_ENABLE = 1'b0;

   // Bus direction
   localparam logic BUS_RW_READ  = 1'b1;
   localparam logic BUS_RW_WRITE = 1'b0;

   // Memory operation carried in EX/MEM
   localparam logic [1:0] MEM_OP_NOP   = 2'd0;
   localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
   localparam logic [1:0] MEM_OP_STORE = 2'd2;

   // Control operation carried through to WB
   localparam logic [1:0] CTRL_OP_NOP  = 2'd0;
   localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
   localparam logic [1:0] CTRL_OP_EXRT = 2'd2;

   // Exception codes
   localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
   localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
   localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd2;
   localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;
   localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
   localparam logic [2:0] ISA_EXP_TRAP       = 3'd5;
   localparam logic [2:0] ISA_EXP_PRV_VIO    = 3'd6;

   // bus_if controller states
   typedef enum logic [1:0] {
      BUS_IF_STATE_IDLE   = 2'd0,
      BUS_IF_STATE_REQ    = 2'd1,
      BUS_IF_STATE_ACCESS = 2'd2,
      BUS_IF_STATE_STALL  = 2'd3
   } bus_if_state_t;

   // Word accesses only: any non-zero byte offset is a misaligned access
   function automatic logic is_miss_align(input logic [1:0] byte_off);
      return (byte_off != 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_if
// Description : Bus master for the MEM stage. Requests the shared bus,
//               strobes one word access once granted, waits for ready and
//               returns the read data. If the pipeline is stalled when the
//               access completes, the read data is buffered (STALL state)
//               until the stall drops.
// Revision    : 1.0 - initial release
// Ports       : clk, reset (async, active-low)
//               i_stall / i_flush       pipeline control
//               o_busy                  access outstanding
//               i_access, i_addr, i_rw, i_wr_data   access request from MEM
//               o_rd_data               read data for the MEM/WB register
//               o_bus_* / i_bus_*       shared bus (active-low req/grnt/as/rdy)
// ============================================================================
module mem_bus_if
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_stall,
   input  logic              i_flush,
   output logic              o_busy,
   input  logic              i_access,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_rw,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_bus_req_,
   input  logic              i_bus_grnt_,
   output logic              o_bus_as_,
   output logic              o_bus_rw,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [DATA_W-1:0] o_bus_wr_data,
   input  logic [DATA_W-1:0] i_bus_rd_data,
   input  logic              i_bus_rdy_
);

   bus_if_state_t     r_state;
   logic [DATA_W-1:0] r_rd_buf;
   logic              w_release;

   // busy is combinational so the controller can freeze upstream in the very
   // cycle the access is first seen; it drops in the ready cycle so the
   // MEM/WB register can take the bus data directly. A flush cancels it.
   always_comb begin
      o_busy    = DISABLE;
      o_rd_data = '0;
      case (r_state)
         BUS_IF_STATE_IDLE: begin
            if (!i_flush && i_access) o_busy = ENABLE;
         end
         BUS_IF_STATE_REQ: begin
            if (!i_flush) o_busy = ENABLE;
         end
         BUS_IF_STATE_ACCESS: begin
            if (i_bus_rdy_ == ENABLE_) o_rd_data = i_bus_rd_data;
            else if (!i_flush)         o_busy    = ENABLE;
         end
         BUS_IF_STATE_STALL: begin
            o_rd_data = r_rd_buf;
         end
         default: begin
            o_busy    = DISABLE;
            o_rd_data = '0;
         end
      endcase
   end

   // Bus is handed back either on completion or on an abandoning flush
   assign w_release = ((r_state == BUS_IF_STATE_REQ) && i_flush) ||
                      ((r_state == BUS_IF_STATE_ACCESS) &&
                       (i_flush || (i_bus_rdy_ == ENABLE_)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= BUS_IF_STATE_IDLE;
         o_bus_req_    <= DISABLE_;
         o_bus_as_     <= DISABLE_;
         o_bus_rw      <= BUS_RW_READ;
         o_bus_addr    <= '0;
         o_bus_wr_data <= '0;
         r_rd_buf      <= '0;
      end else begin
         case (r_state)
            BUS_IF_STATE_IDLE: begin
               if (!i_flush && i_access) begin
                  r_state       <= BUS_IF_STATE_REQ;
                  o_bus_req_    <= ENABLE_;
                  o_bus_addr    <= i_addr;
                  o_bus_rw      <= i_rw;
                  o_bus_wr_data <= i_wr_data;
               end
            end
            BUS_IF_STATE_REQ: begin
               if (i_flush) begin
                  r_state <= BUS_IF_STATE_IDLE;
               end else if (i_bus_grnt_ == ENABLE_) begin
                  r_state   <= BUS_IF_STATE_ACCESS;
                  o_bus_as_ <= ENABLE_;
               end
            end
            BUS_IF_STATE_ACCESS: begin
               // Address strobe lasts exactly one cycle
               o_bus_as_ <= DISABLE_;
               if (i_flush) begin
                  r_state <= BUS_IF_STATE_IDLE;
               end else if (i_bus_rdy_ == ENABLE_) begin
                  if (i_stall) begin
                     r_state  <= BUS_IF_STATE_STALL;
                     r_rd_buf <= i_bus_rd_data;
                  end else begin
                     r_state <= BUS_IF_STATE_IDLE;
                  end
               end
            end
            BUS_IF_STATE_STALL: begin
               if (!i_stall) r_state <= BUS_IF_STATE_IDLE;
            end
            default: begin
               r_state <= BUS_IF_STATE_IDLE;
            end
         endcase

         if (w_release) begin
            o_bus_req_    <= DISABLE_;
            o_bus_rw      <= BUS_RW_READ;
            o_bus_addr    <= '0;
            o_bus_wr_data <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM stage of the 5-stage pipeline. Consumes the EX/MEM
//               register, performs word loads/stores on the shared bus via
//               mem_bus_if and produces the MEM/WB register.
//               Optional macro MEM_ALIGN_CHECK_EN: when defined, a load/store
//               whose byte offset ex_out[1:0] is non-zero makes no bus access
//               and reports ISA_EXP_MISS_ALIGN; when undefined the offset is
//               ignored.
// Revision    : 1.0 - initial release
// Ports       : clk, reset (async, active-low), stall, flush, busy
//               ex_*   EX/MEM register inputs
//               bus_*  shared bus (active-low req/grnt/as/rdy)
//               mem_*  MEM/WB register outputs
// ============================================================================
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   output logic              busy,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic              ex_en,
   input  logic              ex_br_flag,
   input  logic [1:0]        ex_mem_op,
   input  logic [DATA_W-1:0] ex_mem_wr_data,
   input  logic [1:0]        ex_ctrl_op,
   input  logic [4:0]        ex_dst_addr,
   input  logic              ex_gpr_we_,
   input  logic [2:0]        ex_exp_code,
   input  logic [DATA_W-1:0] ex_out,
   output logic              bus_req_,
   input  logic              bus_grnt_,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_,
   output logic [ADDR_W-1:0] mem_pc,
   output logic              mem_en,
   output logic              mem_br_flag,
   output logic [1:0]        mem_ctrl_op,
   output logic [4:0]        mem_dst_addr,
   output logic              mem_gpr_we_,
   output logic [2:0]        mem_exp_code,
   output logic [DATA_W-1:0] mem_out
);

   logic              w_miss_align;
   logic              w_access;
   logic              w_rw;
   logic [DATA_W-1:0] w_rd_data;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_miss_align = ex_en && (ex_mem_op != MEM_OP_NOP) &&
                         is_miss_align(ex_out[1:0]);
`else
   assign w_miss_align = 1'b0;
`endif

   assign w_access = ex_en && (ex_mem_op != MEM_OP_NOP) && !w_miss_align;
   assign w_rw     = (ex_mem_op == MEM_OP_LOAD) ? BUS_RW_READ : BUS_RW_WRITE;

   mem_bus_if #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_bus_if (
      .clk           (clk),
      .reset         (reset),
      .i_stall       (stall),
      .i_flush       (flush),
      .o_busy        (busy),
      .i_access      (w_access),
      .i_addr        (ex_out[ADDR_W+1:2]),
      .i_rw          (w_rw),
      .i_wr_data     (ex_mem_wr_data),
      .o_rd_data     (w_rd_data),
      .o_bus_req_    (bus_req_),
      .i_bus_grnt_   (bus_grnt_),
      .o_bus_as_     (bus_as_),
      .o_bus_rw      (bus_rw),
      .o_bus_addr    (bus_addr),
      .o_bus_wr_data (bus_wr_data),
      .i_bus_rd_data (bus_rd_data),
      .i_bus_rdy_    (bus_rdy_)
   );

   // MEM/WB pipeline register; stall has priority over flush
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_pc       <= '0;
         mem_en       <= DISABLE;
         mem_br_flag  <= DISABLE;
         mem_ctrl_op  <= CTRL_OP_NOP;
         mem_dst_addr <= '0;
         mem_gpr_we_  <= DISABLE_;
         mem_exp_code <= ISA_EXP_NO_EXP;
         mem_out      <= '0;
      end else if (!stall) begin
         if (flush) begin
            mem_pc       <= '0;
            mem_en       <= DISABLE;
            mem_br_flag  <= DISABLE;
            mem_ctrl_op  <= CTRL_OP_NOP;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= DISABLE_;
            mem_exp_code <= ISA_EXP_NO_EXP;
            mem_out      <= '0;
         end else if (w_miss_align) begin
            // Keep pc/en/br_flag so the exception is attributed correctly
            mem_pc       <= ex_pc;
            mem_en       <= ex_en;
            mem_br_flag  <= ex_br_flag;
            mem_ctrl_op  <= CTRL_OP_NOP;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= DISABLE_;
            mem_exp_code <= ISA_EXP_MISS_ALIGN;
            mem_out      <= '0;
         end else begin
            mem_pc       <= ex_pc;
            mem_en       <= ex_en;
            mem_br_flag  <= ex_br_flag;
            mem_ctrl_op  <= ex_ctrl_op;
            mem_dst_addr <= ex_dst_addr;
            mem_gpr_we_  <= ex_gpr_we_;
            mem_exp_code <= ex_exp_code;
            mem_out      <= (ex_en && (ex_mem_op == MEM_OP_LOAD)) ? w_rd_data : ex_out;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. A bus-slave model with
//               programmable grant/ready delays answers each access; the
//               expected MEM/WB contents, busy profile and bus fields are
//               derived from the instruction presented to the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
   import mem_stage_pkg::*;

   typedef struct packed {
      logic [29:0] pc;  logic en;  logic br;  logic [1:0] op;
      logic [31:0] wd;  logic [1:0] ctrl;  logic [4:0] dst;
      logic we_;  logic [2:0] exp;  logic [31:0] out;
   } ex_t;

   typedef struct packed {
      logic [29:0] pc;  logic en;  logic br;  logic [1:0] ctrl;
      logic [4:0] dst;  logic we_;  logic [2:0] exp;  logic [31:0] out;
   } mem_t;

   localparam mem_t BUBBLE = '{pc: '0, en: 1'b0, br: 1'b0, ctrl: CTRL_OP_NOP,
                               dst: '0, we_: 1'b1, exp: ISA_EXP_NO_EXP, out: '0};
   localparam ex_t NOP_I = '{pc: '0, en: 1'b0, br: 1'b0, op: MEM_OP_NOP, wd: '0,
                             ctrl: CTRL_OP_NOP, dst: '0, we_: 1'b1,
                             exp: ISA_EXP_NO_EXP, out: '0};

   logic        clk = 1'b0;
   logic        reset, flush, ext_stall, stall, busy;
   logic [29:0] ex_pc;
   logic        ex_en, ex_br_flag, ex_gpr_we_;
   logic [1:0]  ex_mem_op, ex_ctrl_op;
   logic [31:0] ex_mem_wr_data, ex_out;
   logic [4:0]  ex_dst_addr;
   logic [2:0]  ex_exp_code;
   logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
   logic [29:0] bus_addr;
   logic [31:0] bus_wr_data, bus_rd_data;
   logic [29:0] mem_pc;
   logic        mem_en, mem_br_flag, mem_gpr_we_;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_out;

   int   n_vec = 0;
   int   n_err = 0;
   mem_t exp_q;

   always #5 clk = ~clk;

   // Pipeline controller: freeze upstream while the stage is busy
   assign stall = ext_stall | busy;

   mem_stage #(.ADDR_W(30), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
      .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
      .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
      .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
      .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
      .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
      .bus_rdy_(bus_rdy_),
      .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
      .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
      .mem_out(mem_out)
   );

   function automatic mem_t read_mem();
      return {mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr,
              mem_gpr_we_, mem_exp_code, mem_out};
   endfunction

   function automatic bit misaligned(input ex_t e);
      bit chk = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      chk = 1'b1;
`endif
      return chk && e.en && (e.op != MEM_OP_NOP) && (e.out[1:0] != 2'b00);
   endfunction

   // Reference: what the MEM/WB register must hold once the instruction retires
   function automatic mem_t predict(input ex_t e, input logic [31:0] rdat);
      mem_t m;
      if (misaligned(e))
         m = '{pc: e.pc, en: e.en, br: e.br, ctrl: CTRL_OP_NOP, dst: '0, we_: 1'b1,
               exp: ISA_EXP_MISS_ALIGN, out: '0};
      else
         m = '{pc: e.pc, en: e.en, br: e.br, ctrl: e.ctrl, dst: e.dst, we_: e.we_,
               exp: e.exp, out: (e.en && e.op == MEM_OP_LOAD) ? rdat : e.out};
      return m;
   endfunction

   task automatic drive_ex(input ex_t e);
      ex_pc = e.pc;  ex_en = e.en;  ex_br_flag = e.br;  ex_mem_op = e.op;
      ex_mem_wr_data = e.wd;  ex_ctrl_op = e.ctrl;  ex_dst_addr = e.dst;
      ex_gpr_we_ = e.we_;  ex_exp_code = e.exp;  ex_out = e.out;
   endtask

   // Present one instruction (called #1 after a rising edge) and act as the
   // bus slave until the stage consumes it. ext_hold keeps the external
   // stall raised for that many cycles after the bus access has finished.
   task automatic run_instr(input ex_t e, input int gdly, input int rdly,
                            input logic [31:0] rdat, input int ext_hold,
                            input string tag, output int busy_cyc);
      bit acc, done, in_acc, rdy_now, consumed, exp_busy;
      int gw, rw, after, cyc;
      mem_t act;
      acc = e.en && (e.op != MEM_OP_NOP) && !misaligned(e);
      done = !acc;  in_acc = 0;  consumed = 0;
      gw = 0;  rw = 0;  after = 0;  cyc = 0;  busy_cyc = 0;
      drive_ex(e);
      ext_stall = (ext_hold > 0);
      while (!consumed) begin
         bus_grnt_ = 1'b1;  bus_rdy_ = 1'b1;  bus_rd_data = $urandom;  rdy_now = 0;
         if (done) begin
            if (after >= ext_hold) ext_stall = 1'b0;
            else after++;
         end else if (in_acc || bus_as_ === 1'b0) begin
            if (in_acc) begin
               n_vec++;
               if (bus_as_ !== 1'b1) begin
                  n_err++;  $display("FAIL %s as_pulse: got %b want 1", tag, bus_as_);
               end
            end
            in_acc = 1;
            n_vec++;
            if ({bus_addr, bus_rw} !== {e.out[31:2], (e.op == MEM_OP_LOAD)}) begin
               n_err++;
               $display("FAIL %s addr/rw: got %h/%b want %h/%b", tag, bus_addr, bus_rw,
                        e.out[31:2], (e.op == MEM_OP_LOAD));
            end
            if (e.op == MEM_OP_STORE) begin
               n_vec++;
               if (bus_wr_data !== e.wd) begin
                  n_err++;  $display("FAIL %s wr_data: got %h want %h", tag, bus_wr_data, e.wd);
               end
            end
            if (rw >= rdly) begin
               bus_rdy_ = 1'b0;  bus_rd_data = rdat;  rdy_now = 1;
            end else rw++;
         end else if (bus_req_ === 1'b0) begin
            if (gw >= gdly) bus_grnt_ = 1'b0;
            else gw++;
         end
         @(negedge clk);
         exp_busy = !done && !rdy_now;
         n_vec++;
         if (busy !== exp_busy) begin
            n_err++;  $display("FAIL %s busy cyc%0d: got %b want %b", tag, cyc, busy, exp_busy);
         end
         if (busy === 1'b1) busy_cyc++;
         if (!acc) begin
            n_vec++;
            if (bus_req_ !== 1'b1) begin
               n_err++;  $display("FAIL %s no_req: got %b want 1", tag, bus_req_);
            end
         end
         if (stall === 1'b0) consumed = 1;
         else begin
            act = read_mem();
            n_vec++;
            if (act !== exp_q) begin
               n_err++;  $display("FAIL %s hold: got %h want %h", tag, act, exp_q);
            end
         end
         @(posedge clk);  #1;
         if (rdy_now) done = 1;
         cyc++;
         if (!consumed && cyc > 60) begin
            n_vec++;  n_err++;
            $display("FAIL %s timeout: got busy=%b want retire within 60 cycles", tag, busy);
            break;
         end
      end
      bus_grnt_ = 1'b1;  bus_rdy_ = 1'b1;  ext_stall = 1'b0;
      if (consumed) exp_q = predict(e, rdat);
      act = read_mem();
      n_vec++;
      if (act !== exp_q) begin
         n_err++;  $display("FAIL %s memwb: got %h want %h", tag, act, exp_q);
      end
      n_vec++;
      if ({bus_req_, bus_as_} !== 2'b11) begin
         n_err++;  $display("FAIL %s bus_release: got %b%b want 11", tag, bus_req_, bus_as_);
      end
   endtask

   task automatic test_reset();
      mem_t act;
      reset = 1'b0;  flush = 1'b0;  ext_stall = 1'b0;
      bus_grnt_ = 1'b1;  bus_rdy_ = 1'b1;  bus_rd_data = '0;
      drive_ex(NOP_I);
      #12;
      act = read_mem();
      n_vec++;
      if (act !== BUBBLE) begin
         n_err++;  $display("FAIL reset memwb: got %h want %h", act, BUBBLE);
      end
      n_vec++;
      if ({bus_req_, bus_as_, bus_rw, busy} !== 4'b1110) begin
         n_err++;  $display("FAIL reset bus_ctl: got %b%b%b%b want 1110", bus_req_, bus_as_, bus_rw, busy);
      end
      n_vec++;
      if ({bus_addr, bus_wr_data} !== 62'd0) begin
         n_err++;  $display("FAIL reset bus_data: got %h/%h want 0/0", bus_addr, bus_wr_data);
      end
      @(negedge clk);  reset = 1'b1;
      @(posedge clk);  #1;
      exp_q = BUBBLE;
   endtask

   task automatic test_load_immediate();
      ex_t e;  int bc;
      e = NOP_I;  e.pc = 30'h40;  e.en = 1;  e.op = MEM_OP_LOAD;  e.out = 32'h100;
      e.we_ = 0;  e.dst = 5'd3;
      run_instr(e, 0, 0, 32'hDEADBEEF, 0, "load_imm", bc);
      n_vec++;
      if (bc != 2) begin n_err++;  $display("FAIL load_imm busy_len: got %0d want 2", bc); end
      n_vec++;
      if (mem_out !== 32'hDEADBEEF) begin
         n_err++;  $display("FAIL load_imm data: got %h want deadbeef", mem_out);
      end
   endtask

   task automatic test_store_delayed();
      ex_t e;  int bc;
      e = NOP_I;  e.pc = 30'h41;  e.en = 1;  e.op = MEM_OP_STORE;  e.out = 32'h40;
      e.wd = 32'h12345678;  e.we_ = 1;
      run_instr(e, 0, 3, 32'hA5A5A5A5, 0, "store_dly", bc);
      n_vec++;
      if (bc != 5) begin n_err++;  $display("FAIL store_dly busy_len: got %0d want 5", bc); end
   endtask

   task automatic test_alu_nop();
      ex_t e;  int bc;
      e = NOP_I;  e.pc = 30'h42;  e.en = 1;  e.out = 32'h55;  e.we_ = 0;  e.dst = 5'd7;
      e.ctrl = CTRL_OP_WRCR;
      run_instr(e, 0, 0, 32'h0, 0, "alu_nop", bc);
      n_vec++;
      if (bc != 0 || mem_out !== 32'h55) begin
         n_err++;  $display("FAIL alu_nop: got busy_len=%0d out=%h want 0/55", bc, mem_out);
      end
   endtask

   task automatic test_misalign();
      ex_t e;  int bc, want;
      e = NOP_I;  e.pc = 30'h43;  e.en = 1;  e.op = MEM_OP_LOAD;  e.out = 32'h102;
      e.we_ = 0;  e.dst = 5'd9;
      want = misaligned(e) ? 0 : 2;
      run_instr(e, 0, 0, 32'hCAFEF00D, 0, "misalign", bc);
      n_vec++;
      if (bc != want) begin n_err++;  $display("FAIL misalign busy_len: got %0d want %0d", bc, want); end
   endtask

   task automatic test_load_stall();
      ex_t e;  int bc;  logic [31:0] d;
      d = $urandom;
      e = NOP_I;  e.pc = 30'h44;  e.en = 1;  e.op = MEM_OP_LOAD;  e.out = 32'h180;
      e.we_ = 0;  e.dst = 5'd4;
      run_instr(e, 1, 1, d, 3, "load_stall", bc);
      n_vec++;
      if (bc != 4 || mem_out !== d) begin
         n_err++;  $display("FAIL load_stall: got busy_len=%0d out=%h want 4/%h", bc, mem_out, d);
      end
   endtask

   task automatic test_flush();
      ex_t e;  mem_t act;
      e = NOP_I;  e.pc = 30'h45;  e.en = 1;  e.op = MEM_OP_LOAD;  e.out = 32'h200;  e.we_ = 0;
      drive_ex(e);  bus_grnt_ = 1'b1;  bus_rdy_ = 1'b1;
      @(posedge clk);  #1;
      n_vec++;
      if (bus_req_ !== 1'b0) begin n_err++;  $display("FAIL flush req: got %b want 0", bus_req_); end
      flush = 1'b1;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0) begin n_err++;  $display("FAIL flush busy: got %b want 0", busy); end
      @(posedge clk);  #1;
      flush = 1'b0;  drive_ex(NOP_I);  exp_q = BUBBLE;
      act = read_mem();
      n_vec++;
      if (act !== BUBBLE) begin n_err++;  $display("FAIL flush memwb: got %h want %h", act, BUBBLE); end
      n_vec++;
      if ({bus_req_, bus_as_} !== 2'b11) begin
         n_err++;  $display("FAIL flush release: got %b%b want 11", bus_req_, bus_as_);
      end
   endtask

   task automatic test_reset_abort();
      ex_t e;  mem_t act;  bit got;
      e = NOP_I;  e.pc = 30'h46;  e.en = 1;  e.op = MEM_OP_LOAD;  e.out = 32'h300;  e.we_ = 0;
      drive_ex(e);  bus_rdy_ = 1'b1;  got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         bus_grnt_ = (bus_req_ === 1'b0) ? 1'b0 : 1'b1;
         @(posedge clk);  #1;
         if (bus_as_ === 1'b0) got = 1;
      end
      n_vec++;
      if (!got) begin n_err++;  $display("FAIL rst_abort start: got as_=%b want 0", bus_as_); end
      #2;  reset = 1'b0;  #1;
      act = read_mem();
      n_vec++;
      if ({bus_req_, bus_as_, bus_rw} !== 3'b111 || bus_addr !== 30'd0) begin
         n_err++;
         $display("FAIL rst_abort bus: got %b%b%b addr=%h want 111 addr=0", bus_req_, bus_as_, bus_rw, bus_addr);
      end
      n_vec++;
      if (act !== BUBBLE) begin n_err++;  $display("FAIL rst_abort memwb: got %h want %h", act, BUBBLE); end
      bus_grnt_ = 1'b1;  drive_ex(NOP_I);
      @(negedge clk);  reset = 1'b1;
      @(posedge clk);  #1;
      exp_q = BUBBLE;
   endtask

   task automatic test_back_to_back();
      ex_t e;  int bc, hold;
      for (int k = 0; k < 40; k++) begin
         e.pc = 30'($urandom);  e.br = 1'($urandom);  e.op = 2'($urandom_range(0, 2));
         e.en = (e.op != MEM_OP_NOP) ? 1'b1 : 1'($urandom_range(0, 1));
         e.wd = $urandom;  e.ctrl = 2'($urandom_range(0, 2));  e.dst = 5'($urandom);
         e.we_ = 1'($urandom);  e.exp = 3'($urandom_range(0, 6));  e.out = $urandom;
         if ($urandom_range(0, 2) != 0) e.out[1:0] = 2'b00;
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         run_instr(e, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                   hold, "random", bc);
      end
   endtask

   initial begin
      test_reset();
      test_load_immediate();
      test_store_delayed();
      test_alu_nop();
      test_misalign();
      test_load_stall();
      test_flush();
      test_reset_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion want finish before 1ms");
      $fatal(1);
   end

endmodule
`default_nettype wire
